// File: rtl/xctcmsg_pkg.sv
// Shared xctcmsg message definitions: bus field widths, meta/message structs and the
// interface-facing send/receive payload types used by buffered_bus_interface.
package xctcmsg_pkg;

    localparam int XCTCMSG_ADDR_W = 32;
    localparam int XCTCMSG_TAG_W  = 32;
    localparam int XCTCMSG_DATA_W = 64;

    typedef struct packed {
        logic [XCTCMSG_ADDR_W-1:0] address;
        logic [XCTCMSG_TAG_W-1:0]  tag;
    } xctcmsg_meta_t;

    typedef struct packed {
        xctcmsg_meta_t             meta;
        logic [XCTCMSG_DATA_W-1:0] data;
    } xctcmsg_message_t;

    typedef xctcmsg_message_t interface_send_data_t;
    typedef xctcmsg_message_t interface_receive_data_t;

    function automatic xctcmsg_message_t xctcmsg_make_message(
        input logic [XCTCMSG_ADDR_W-1:0] address,
        input logic [XCTCMSG_TAG_W-1:0]  tag,
        input logic [XCTCMSG_DATA_W-1:0] data
    );
        xctcmsg_message_t m;
        m.meta.address = address;
        m.meta.tag     = tag;
        m.data         = data;
        return m;
    endfunction

endpackage

// File: rtl/xctcmsg_fifo.sv
// Generic synchronous FIFO of element type T with power-of-two DEPTH, synchronous flush
// and a registered-storage head output (no combinational write-to-head path).
module xctcmsg_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic pop_i,
    input  logic flush_i,
    input  T     data_i,
    output logic full_o,
    output logic empty_o,
    output T     head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_ONE;
            end else if (!do_push && do_pop) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy is governed solely by the pointers above.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/buffered_bus_interface.sv
// Buffered bridge between post office/mailbox and the inter-node message bus, with a send
// FIFO and a receive FIFO. Optional send/receive counters are enabled by XCTCMSG_BUS_STATS_EN.
module buffered_bus_interface
    import xctcmsg_pkg::*;
#(
    parameter int SEND_DEPTH = 4,
    parameter int RECV_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    postoffice_interface_valid,
    output logic                    interface_postoffice_ready,
    input  interface_send_data_t    postoffice_interface_data,
    output logic                    interface_mailbox_valid,
    input  logic                    mailbox_interface_ready,
    output interface_receive_data_t interface_mailbox_data,
    output logic                    bus_val_o,
    input  logic                    bus_ack_i,
    output logic [31:0]             bus_dst_o,
    output logic [31:0]             bus_tag_o,
    output logic [63:0]             bus_msg_o,
    output logic                    bus_rdy_o,
    input  logic                    bus_val_i,
    input  logic [31:0]             bus_src_i,
    input  logic [31:0]             bus_tag_i,
    input  logic [63:0]             bus_msg_i
`ifdef XCTCMSG_BUS_STATS_EN
    ,
    output logic [31:0]             sent_count_o,
    output logic [31:0]             recv_count_o
`endif
);

    logic                    send_full, send_empty, send_push, send_pop;
    logic                    recv_full, recv_empty, recv_push, recv_pop;
    interface_send_data_t    send_head;
    interface_receive_data_t recv_entry;

    // Send side: a same-cycle bus ack frees a slot, so ready may bypass the full flag.
    assign send_pop                   = bus_val_o & bus_ack_i;
    assign interface_postoffice_ready = ~send_full | send_pop;
    assign send_push                  = postoffice_interface_valid & interface_postoffice_ready;
    assign bus_val_o                  = ~send_empty;
    assign bus_dst_o                  = send_head.meta.address;
    assign bus_tag_o                  = send_head.meta.tag;
    assign bus_msg_o                  = send_head.data;

    xctcmsg_fifo #(
        .T     (interface_send_data_t),
        .DEPTH (SEND_DEPTH)
    ) u_send_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (send_push),
        .pop_i   (send_pop),
        .flush_i (flush),
        .data_i  (postoffice_interface_data),
        .full_o  (send_full),
        .empty_o (send_empty),
        .head_o  (send_head)
    );

    // Receive side mirrors the send side; flush never touches messages already owned here.
    assign interface_mailbox_valid = ~recv_empty;
    assign recv_pop                = interface_mailbox_valid & mailbox_interface_ready;
    assign bus_rdy_o               = ~recv_full | recv_pop;
    assign recv_push               = bus_val_i & bus_rdy_o;
    assign recv_entry              = xctcmsg_make_message(bus_src_i, bus_tag_i, bus_msg_i);

    xctcmsg_fifo #(
        .T     (interface_receive_data_t),
        .DEPTH (RECV_DEPTH)
    ) u_recv_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (recv_push),
        .pop_i   (recv_pop),
        .flush_i (1'b0),
        .data_i  (recv_entry),
        .full_o  (recv_full),
        .empty_o (recv_empty),
        .head_o  (interface_mailbox_data)
    );

`ifdef XCTCMSG_BUS_STATS_EN
    logic [31:0] sent_count_q, sent_count_d;
    logic [31:0] recv_count_q, recv_count_d;

    // A pop acknowledged during a flush still counts as delivered.
    always_comb begin
        sent_count_d = sent_count_q;
        recv_count_d = recv_count_q;
        if (send_pop) begin
            sent_count_d = sent_count_q + 32'd1;
        end
        if (recv_push) begin
            recv_count_d = recv_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent_count_q <= '0;
            recv_count_q <= '0;
        end else begin
            sent_count_q <= sent_count_d;
            recv_count_q <= recv_count_d;
        end
    end

    assign sent_count_o = sent_count_q;
    assign recv_count_o = recv_count_q;
`endif

endmodule

// File: tb/tb_buffered_bus_interface.sv
// Directed self-checking bench for buffered_bus_interface; stats checks are compiled in
// when XCTCMSG_BUS_STATS_EN is defined.
module tb_buffered_bus_interface;
    import xctcmsg_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic                    po_valid;
    logic                    po_ready;
    interface_send_data_t    po_data;
    logic                    mb_valid;
    logic                    mb_ready;
    interface_receive_data_t mb_data;
    logic                    bus_val_o, bus_ack_i, bus_rdy_o, bus_val_i;
    logic [31:0]             bus_dst_o, bus_tag_o, bus_src_i, bus_tag_i;
    logic [63:0]             bus_msg_o, bus_msg_i;
`ifdef XCTCMSG_BUS_STATS_EN
    logic [31:0]             sent_count_o, recv_count_o;
`endif

    int nerr = 0;
    int nchk = 0;
    int exp_send, exp_recv;

    always #5 clk = ~clk;

    buffered_bus_interface #(.SEND_DEPTH(4), .RECV_DEPTH(4)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .flush                      (flush),
        .postoffice_interface_valid (po_valid),
        .interface_postoffice_ready (po_ready),
        .postoffice_interface_data  (po_data),
        .interface_mailbox_valid    (mb_valid),
        .mailbox_interface_ready    (mb_ready),
        .interface_mailbox_data     (mb_data),
        .bus_val_o                  (bus_val_o),
        .bus_ack_i                  (bus_ack_i),
        .bus_dst_o                  (bus_dst_o),
        .bus_tag_o                  (bus_tag_o),
        .bus_msg_o                  (bus_msg_o),
        .bus_rdy_o                  (bus_rdy_o),
        .bus_val_i                  (bus_val_i),
        .bus_src_i                  (bus_src_i),
        .bus_tag_i                  (bus_tag_i),
        .bus_msg_i                  (bus_msg_i)
`ifdef XCTCMSG_BUS_STATS_EN
        ,
        .sent_count_o               (sent_count_o),
        .recv_count_o               (recv_count_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_send(input logic v, input int tag);
        po_valid = v;
        po_data  = xctcmsg_make_message(32'h100 + 32'(tag), 32'(tag), 64'hA000 + 64'(tag));
    endtask

    task automatic set_recv(input logic v, input int src);
        bus_val_i = v;
        bus_src_i = 32'(src);
        bus_tag_i = 32'h20 + 32'(src);
        bus_msg_i = 64'hB000 + 64'(src);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; bus_ack_i = 1'b0; mb_ready = 1'b0;
        set_send(1'b0, 0);
        set_recv(1'b0, 0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_po_ready", po_ready, 1);
        chk("rst_bus_val", bus_val_o, 0);
        chk("rst_bus_rdy", bus_rdy_o, 1);
        chk("rst_mb_valid", mb_valid, 0);
`ifdef XCTCMSG_BUS_STATS_EN
        chk("rst_sent_cnt", sent_count_o, 0);
        chk("rst_recv_cnt", recv_count_o, 0);
`endif

        // Fill the send FIFO with no acks
        for (int i = 1; i <= 4; i++) begin
            set_send(1'b1, i);
            #1;
            chk("fill_ready", po_ready, 1);
            chk("fill_bus_val_latency", bus_val_o, (i > 1) ? 1 : 0);
            tick();
        end
        set_send(1'b1, 5);
        #1;
        chk("full_ready_low", po_ready, 0);
        chk("full_head_tag", bus_tag_o, 1);
        tick();
        set_send(1'b0, 0);
        #1;
        chk("stable_head_tag", bus_tag_o, 1);
        chk("stable_head_dst", bus_dst_o, 32'h101);
        for (int i = 1; i <= 4; i++) begin
            bus_ack_i = 1'b1;
            #1;
            chk("drain_val", bus_val_o, 1);
            chk("drain_tag", bus_tag_o, i);
            chk("drain_dst", bus_dst_o, 32'h100 + i);
            chk("drain_msg", bus_msg_o, 64'hA000 + i);
            tick();
        end
        bus_ack_i = 1'b0;
        #1;
        chk("drain_empty", bus_val_o, 0);

        // Simultaneous push and pop on a full FIFO
        for (int i = 1; i <= 4; i++) begin
            set_send(1'b1, i);
            tick();
        end
        set_send(1'b1, 5);
        bus_ack_i = 1'b1;
        #1;
        chk("bypass_ready", po_ready, 1);
        chk("bypass_head", bus_tag_o, 1);
        tick();
        set_send(1'b0, 0);
        bus_ack_i = 1'b0;
        #1;
        chk("bypass_still_full", po_ready, 0);
        for (int i = 2; i <= 5; i++) begin
            bus_ack_i = 1'b1;
            #1;
            chk("bypass_order", bus_tag_o, i);
            tick();
        end
        bus_ack_i = 1'b0;
        #1;
        chk("bypass_empty", bus_val_o, 0);

        // Flush with 3 queued, ack and push in the same cycle
        for (int i = 21; i <= 23; i++) begin
            set_send(1'b1, i);
            tick();
        end
        set_send(1'b1, 99);
        flush = 1'b1;
        bus_ack_i = 1'b1;
        #1;
        chk("flush_head", bus_tag_o, 21);
        tick();
        flush = 1'b0;
        bus_ack_i = 1'b0;
        set_send(1'b0, 0);
        #1;
        chk("flush_val_low", bus_val_o, 0);
        chk("flush_ready", po_ready, 1);
        tick();
        chk("flush_push_dropped", bus_val_o, 0);
`ifdef XCTCMSG_BUS_STATS_EN
        chk("flush_sent_cnt", sent_count_o, 10);
`endif

        // Receive FIFO fill with mailbox stalled
        mb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_recv(1'b1, 32'h10 + i);
            #1;
            chk("rx_fill_rdy", bus_rdy_o, 1);
            chk("rx_valid_latency", mb_valid, (i > 0) ? 1 : 0);
            tick();
        end
        set_recv(1'b1, 32'h14);
        #1;
        chk("rx_full_rdy_low", bus_rdy_o, 0);
        tick();
        set_recv(1'b0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rx_valid", mb_valid, 1);
            chk("rx_src", mb_data.meta.address, 32'h10 + i);
            chk("rx_tag", mb_data.meta.tag, 32'h30 + i);
            chk("rx_msg", mb_data.data, 64'hB010 + i);
            tick();
        end
        #1;
        chk("rx_empty", mb_valid, 0);
        mb_ready = 1'b0;

        // Reset with a send in flight, then a 100-message dual stream
        set_send(1'b1, 7);
        tick();
        set_send(1'b0, 0);
        rst = 1'b1;
        #1;
        chk("midrst_val", bus_val_o, 0);
        tick();
        rst = 1'b0;
        bus_ack_i = 1'b1;
        mb_ready = 1'b1;
        exp_send = 1000;
        exp_recv = 2000;
        for (int c = 0; c < 102; c++) begin
            set_send(c < 100, 1000 + c);
            set_recv(c < 100, 2000 + c);
            #1;
            if (c < 100) begin
                chk("stream_po_ready", po_ready, 1);
                chk("stream_bus_rdy", bus_rdy_o, 1);
            end
            if (bus_val_o) begin
                chk("stream_send_tag", bus_tag_o, exp_send);
                exp_send++;
            end
            if (mb_valid) begin
                chk("stream_recv_src", mb_data.meta.address, exp_recv);
                exp_recv++;
            end
            tick();
        end
        chk("stream_send_total", exp_send, 1100);
        chk("stream_recv_total", exp_recv, 2100);
`ifdef XCTCMSG_BUS_STATS_EN
        chk("stream_sent_cnt", sent_count_o, 100);
        chk("stream_recv_cnt", recv_count_o, 100);

        // Sent counter wrap
        bus_ack_i = 1'b0;
        force dut.sent_count_q = 32'hFFFFFFFF;
        #1;
        release dut.sent_count_q;
        #1;
        chk("wrap_preset", sent_count_o, 32'hFFFFFFFF);
        set_send(1'b1, 3);
        tick();
        set_send(1'b0, 0);
        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0;
        chk("wrap_zero", sent_count_o, 0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
